// File: rtl/d_regdump_if.sv
// Dump engine bus: control (start/busy/done), register-file read port and byte stream.
// Ports: start/busy/done, rd_addr/rd_data toward the register file, tx_data/tx_valid/tx_ready.
// master = dump engine side, slave = CPU/register file/UART side.
interface d_regdump_if #(
    parameter int AW = 5
) ();
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport master (
        input  start, rd_data, tx_ready,
        output busy, done, rd_addr, tx_data, tx_valid
    );

    modport slave (
        output start, rd_data, tx_ready,
        input  busy, done, rd_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/d_regdump.sv
// Register-file dump engine: on start, streams a SYNC byte then every register as 4 LE bytes.
// Ports: clk, rst (async active-high), bus (master modport of d_regdump_if).
// Latency: 1 HDR cycle then 5 cycles/register with tx_ready high; tx holds while tx_ready is low.
module d_regdump #(
    parameter int         NREGS = 32,
    parameter int         AW    = 5,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    d_regdump_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [1:0]    bcnt;

    // Registered outputs, updated together with the state they decode.
    logic          busy_q;
    logic          done_q;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;

    assign bus.rd_addr  = idx;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            word       <= '0;
            bcnt       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (bus.start) begin
                        state      <= HDR;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC;
                    end
                end
                HDR: begin
                    if (bus.tx_ready) begin
                        state      <= FETCH;
                        tx_valid_q <= 1'b0;
                    end
                end
                FETCH: begin
                    // Snapshot this register; the first byte is presented straight from the
                    // read port so tx_data is registered in step with tx_valid.
                    word       <= bus.rd_data;
                    bcnt       <= 2'd0;
                    state      <= SEND;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= bus.rd_data[7:0];
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        word <= word >> 8;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= FETCH;
                            end
                        end else begin
                            tx_data_q <= word[15:8];
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_d_regdump.sv
// Self-checking bench for d_regdump: scoreboard of expected bytes built from a register
// snapshot model; a negedge monitor pops/compares each accepted byte and checks protocol rules.
module tb_d_regdump;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int TOTAL = 1 + 4 * NREGS;

    logic clk;
    logic rst;
    logic [31:0] regs [NREGS];

    d_regdump_if #(.AW(AW)) bus ();

    d_regdump #(.NREGS(NREGS), .AW(AW), .SYNC(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file read port: register 0 is hardwired to zero.
    assign bus.rd_data = (bus.rd_addr == '0) ? 32'd0 : regs[bus.rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard
    logic [7:0] exp_q[$];
    int         rx_cnt;
    int         first_vld_cyc;
    int         done_cyc;
    bit         seen_first;
    bit         prev_stall;
    bit         prev_done;
    logic [7:0] prev_data;

    // Expected stream: SYNC, then each register value as 4 little-endian bytes.
    task automatic push_dump(input logic [31:0] snap [NREGS]);
        logic [31:0] v;
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NREGS; r++) begin
            v = (r == 0) ? 32'd0 : snap[r];
            for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic new_dump();
        rx_cnt     = 0;
        seen_first = 0;
        first_vld_cyc = 0;
        done_cyc   = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(bus.tx_valid), 32'd1);
                chk("stall_data_hold", 32'(bus.tx_data), 32'(prev_data));
            end
            if (prev_done) begin
                chk("done_one_cycle", 32'(bus.done), 32'd0);
                chk("busy_after_done", 32'(bus.busy), 32'd0);
            end
            if (bus.done) begin
                done_cyc = cyc;
                chk("busy_during_done", 32'(bus.busy), 32'd1);
            end
            if (bus.tx_valid && !seen_first) begin
                seen_first    = 1;
                first_vld_cyc = cyc;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("byte%0d", rx_cnt), 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    chk("busy_while_tx", 32'(bus.busy), 32'd1);
                    if (rx_cnt > 0)
                        chk("rd_addr_in_send", 32'(bus.rd_addr), 32'((rx_cnt - 1) / 4));
                end
                rx_cnt++;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_done  = bus.done;
        end
    end

    // tx_ready driver: 0 = always high, 1 = ~30% random, 2 = always low
    int rdy_mode = 0;
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ($urandom_range(0, 99) < 30);
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input int n, input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rx_cnt >= n) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic end_of_dump(input string name);
        chk({name, "_bytes"}, 32'(rx_cnt), 32'(TOTAL));
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h1122_3300 + 32'(i);
    endtask

    logic [31:0] snap [NREGS];

    initial begin
        bus.start = 1'b0;
        preload();
        new_dump();

        // Reset with a start pulse inside it
        rst = 1'b1;
        #2 bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);

        // Full dump, tx_ready high
        rdy_mode = 0;
        new_dump();
        snap = regs;
        push_dump(snap);
        pulse_start();
        wait_done(400, "full");
        end_of_dump("full");
        chk("full_done_latency", 32'(done_cyc - first_vld_cyc), 32'd161);
        repeat (3) @(posedge clk);

        // Random backpressure
        rdy_mode = 1;
        new_dump();
        snap = regs;
        push_dump(snap);
        pulse_start();
        wait_done(4000, "bp");
        end_of_dump("bp");
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        // Writes during dump: reg 20 before its fetch, reg 3 after its fetch
        new_dump();
        snap = regs;
        snap[20] = 32'hDEAD_BEEF;
        push_dump(snap);
        pulse_start();
        wait_bytes(22, "wr20");
        regs[20] = 32'hDEAD_BEEF;
        wait_bytes(30, "wr3");
        regs[3] = 32'hCAFE_F00D;
        wait_done(400, "wr");
        end_of_dump("wr");
        preload();
        repeat (3) @(posedge clk);

        // Reset while stalled in SEND
        new_dump();
        snap = regs;
        push_dump(snap);
        pulse_start();
        wait_bytes(10, "midrst");
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        chk("midrst_stalled_valid", 32'(bus.tx_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_restart", 32'(bus.busy), 32'd0);
        new_dump();
        push_dump(snap);
        pulse_start();
        wait_done(400, "restart");
        end_of_dump("restart");
        repeat (3) @(posedge clk);

        // Start while busy (byte 40) and in the DONE cycle
        new_dump();
        snap = regs;
        push_dump(snap);
        pulse_start();
        wait_bytes(40, "sb");
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(400, "sb");
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        end_of_dump("sb");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sb_idle_busy", 32'(bus.busy), 32'd0);
            chk("sb_idle_valid", 32'(bus.tx_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/d_regdump.md
# d_regdump

Register-file dump engine for the single-cycle CPU debug path. On a `start` pulse it walks register indices 0..NREGS-1 through a spare combinational read port of `d_reg32file`, captures each 32-bit value, and streams it out as bytes over a valid/ready interface toward the UART transmitter. It is the reader counterpart to the register file's write port and runs alongside normal CPU execution without stalling it.

## Interface
- `NREGS`, 32, number of registers dumped, indices 0..NREGS-1
- `AW`, 5, width of the register address
- `SYNC`, 8'hA5, framing byte sent before the first register
- `clk`  in  1  system clock, all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a dump; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left
- `done`  out  1  one-cycle pulse after the last byte is accepted
- `rd_addr`  out  AW  register index driven to the register file read port (`rb`)
- `rd_data`  in  32  combinational read data from the register file (`busb`)
- `tx_data`  out  8  byte to transmit
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  sink accepts the byte this cycle

## Operation
- Registers: `state`, `idx` (AW bits), `word` (32 bits), `bcnt` (2 bits).
- States: IDLE, HDR, FETCH, SEND, DONE.
- IDLE: `busy`=0, `tx_valid`=0, `idx`=0. `start`=1 -> HDR.
- HDR: `tx_valid`=1, `tx_data`=SYNC. Handshake (`tx_valid & tx_ready`) -> FETCH.
- FETCH: `rd_addr`=`idx`; `word` <= `rd_data`, `bcnt` <= 0 -> SEND. `tx_valid`=0.
- SEND: `tx_valid`=1, `tx_data`=`word[7:0]` (little-endian). On handshake: `word` <= `word >> 8`, `bcnt` <= `bcnt+1`. If `bcnt`==3 on the handshake: if `idx`==NREGS-1 -> DONE, otherwise `idx` <= `idx+1` -> FETCH.
- DONE: `done`=1 for exactly one cycle, `idx` <= 0 -> IDLE.
- `rd_addr` equals `idx` in every state (0 in IDLE).
- Stream per dump: 1 SYNC byte + 4*NREGS data bytes (129 for the defaults).
- Snapshot semantics: each register is captured in its own FETCH cycle. A CPU write to register k in the same cycle as FETCH of k is not seen (the file updates on the same edge). Later writes to already-fetched registers are not reflected.
- Register 0 is dumped as whatever the file returns (0).
- `start` is ignored in every state other than IDLE, including DONE.
- `tx_ready` without `tx_valid` has no effect. `tx_data` is don't-care while `tx_valid`=0.

## Timing
- Reset values: `state`=IDLE, `idx`=0, `word`=0, `bcnt`=0. Outputs: `busy`=0, `done`=0, `tx_valid`=0, `tx_data`=0, `rd_addr`=0.
- `rst` asserted at any point, including mid-byte, forces IDLE immediately and asynchronously. `tx_valid` drops without waiting for `tx_ready`. A new `start` is required after reset releases.
- `start` sampled at edge k gives HDR from edge k: `busy`=1 and `tx_valid`=1 in cycle k+1.
- Handshake rule: while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `state`, `word`, `bcnt` and `idx` hold stable. `tx_valid` never drops without a handshake (except on reset).
- FETCH takes exactly one cycle. There is a one-cycle `tx_valid` bubble before each register.
- With `tx_ready` held high: 1 HDR cycle, then 5 cycles per register; `done` rises 1+5*NREGS cycles after HDR entry (161 for the defaults). `busy` falls the cycle after `done`.
- `busy` and `done` are registered state decodes and are glitch-free.

## Test plan
- Reset: assert `rst` for 3 cycles -> all outputs 0. Pulse `start` during reset -> no effect, `busy`=0 after release.
- Full dump, `tx_ready`=1: preload regs[i]=32'h11223300+i, pulse `start` -> byte 0=A5; for reg 1 the bytes are 01,33,22,11; 129 bytes total; `done` 161 cycles after the first `tx_valid`.
- Backpressure: randomly toggle `tx_ready` (about 30% high) -> same 129-byte sequence, `tx_data` stable while stalled, no dropped or duplicated bytes.
- Write during dump: write regs[20]=DEADBEEF while `idx`=5, and regs[3]=CAFEF00D after reg 3 is fetched -> dump shows DEADBEEF for reg 20 and the old value for reg 3.
- Reset mid-dump: assert `rst` while in SEND with `tx_ready`=0 -> `tx_valid`=0 immediately. A new `start` restarts from A5 and reg 0.
- Start while busy: pulse `start` at byte 40 and in the DONE cycle -> the stream is unaffected and no second dump begins; `busy`=0 after `done`.
